deco_3_8_s: RTL



---
 rtl/deco_3_8_s_if.sv | 25 ++
 rtl/deco_3_8_s.sv | 107 ++++++++++
 2 files changed

// File: rtl/deco_3_8_s_if.sv
// Code-in / one-hot-out bundle for the sequenced 3-to-8 decoder.
// The producer/consumer side uses master; the decoder uses slave.
interface deco_3_8_s_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          a_valid;
  logic [2:0]    a;
  logic          a_ready;
  logic [7:0]    d;
  logic          d_valid;
  logic [LW-1:0] level;
  logic          busy;

  modport master (
    output a_valid, a,
    input  a_ready, d, d_valid, level, busy
  );

  modport slave (
    input  a_valid, a,
    output a_ready, d, d_valid, level, busy
  );
endinterface

// File: rtl/deco_3_8_s.sv
// Sequenced 3-to-8 decoder: buffers 3-bit codes in a FIFO and drives each
// as a registered one-hot word for HOLD cycles, back-to-back when backlogged.
module deco_3_8_s #(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  deco_3_8_s_if.slave  bus
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              LW       = AW + 1;
  localparam logic [7:0]      HOLD_M1  = 8'(HOLD - 1);
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t        state, state_n;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [7:0]    hold_cnt, hold_cnt_n;
  logic [7:0]    d_q, d_n;
  logic          d_valid_q, d_valid_n;
  logic          full, empty, push, pop;
  logic [2:0]    head;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  // Readiness comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign push  = bus.a_valid & ~full;
  assign head  = mem[rd_ptr];

  // NOTE: FIFO storage has no reset; contents are only observable through count, which is reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.a;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      d_q       <= '0;
      d_valid_q <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_cnt_n;
      d_q       <= d_n;
      d_valid_q <= d_valid_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    d_n        = d_q;
    d_valid_n  = d_valid_q;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          d_n        = 8'd1 << head;
          d_valid_n  = 1'b1;
          hold_cnt_n = HOLD_M1;
          state_n    = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_cnt != 8'd0) begin
          hold_cnt_n = hold_cnt - 8'd1;
        end else if (!empty) begin
          // Reload straight from the FIFO so consecutive words abut with no zero cycle.
          pop        = 1'b1;
          d_n        = 8'd1 << head;
          hold_cnt_n = HOLD_M1;
        end else begin
          d_n       = 8'd0;
          d_valid_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.a_ready = ~full;
  assign bus.d       = d_q;
  assign bus.d_valid = d_valid_q;
  assign bus.level   = count;
  assign bus.busy    = d_valid_q | ~empty;
endmodule
